// File: rtl/seg_display_scan.sv
// Four-digit multiplexed seven-segment scanner driven by a synchronised DisplayCLK tick.
// Inserts an all-dark guard gap between digits and reloads its display shadows once per frame.
module seg_display_scan #(
    parameter int GUARD_CYCLES = 16,
    parameter bit LZS          = 1'b1
) (
    input  logic        CLK100MHz,
    input  logic        RST,
    input  logic        DisplayCLK,
    input  logic [15:0] VALUE,
    input  logic [3:0]  DP_IN,
    input  logic [3:0]  BLANK_IN,
    output logic [3:0]  AN,
    output logic [6:0]  SEG,
    output logic        DP,
    output logic        FRAME_DONE
);

    typedef enum logic [1:0] {S_OFF, S_GUARD, S_ON} state_t;

    localparam logic [15:0] GUARD_LAST = 16'(GUARD_CYCLES - 1);

    state_t      r_state;
    logic [1:0]  r_idx;
    logic [15:0] r_gcnt;
    logic        r_s1, r_s2, r_prev;
    logic [15:0] r_val_sh;
    logic [3:0]  r_dp_sh;
    logic [3:0]  r_blank_sh;

    logic        w_tick;
    logic [3:0]  w_nib;
    logic [3:0]  w_lzs_dark;
    logic        w_dark;

    function automatic logic [6:0] f_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    assign w_tick = r_s2 & ~r_prev;

    always_comb begin
        w_nib = 4'h0;
        case (r_idx)
            2'd0: w_nib = r_val_sh[3:0];
            2'd1: w_nib = r_val_sh[7:4];
            2'd2: w_nib = r_val_sh[11:8];
            default: w_nib = r_val_sh[15:12];
        endcase
        // A digit is a leading zero when it and every more-significant nibble is zero.
        w_lzs_dark[0] = 1'b0;
        w_lzs_dark[1] = LZS && (r_val_sh[15:4] == 12'h000);
        w_lzs_dark[2] = LZS && (r_val_sh[15:8] == 8'h00);
        w_lzs_dark[3] = LZS && (r_val_sh[15:12] == 4'h0);
        w_dark = r_blank_sh[r_idx] | w_lzs_dark[r_idx];
    end

    always_ff @(posedge CLK100MHz or posedge RST) begin
        if (RST) begin
            r_state    <= S_OFF;
            r_idx      <= 2'd0;
            r_gcnt     <= 16'd0;
            r_s1       <= 1'b0;
            r_s2       <= 1'b0;
            r_prev     <= 1'b0;
            r_val_sh   <= 16'h0000;
            r_dp_sh    <= 4'h0;
            r_blank_sh <= 4'h0;
            AN         <= 4'hF;
            SEG        <= 7'h7F;
            DP         <= 1'b1;
            FRAME_DONE <= 1'b0;
        end else begin
            r_s1       <= DisplayCLK;
            r_s2       <= r_s1;
            r_prev     <= r_s2;
            FRAME_DONE <= 1'b0;

            case (r_state)
                S_OFF: begin
                    if (w_tick) begin
                        r_state    <= S_GUARD;
                        r_idx      <= 2'd3;
                        r_gcnt     <= 16'd0;
                        r_val_sh   <= VALUE;
                        r_dp_sh    <= DP_IN;
                        r_blank_sh <= BLANK_IN;
                        FRAME_DONE <= 1'b1;
                    end
                end
                S_ON: begin
                    if (w_tick) begin
                        r_state <= S_GUARD;
                        r_gcnt  <= 16'd0;
                        if (r_idx == 2'd3) begin
                            r_val_sh   <= VALUE;
                            r_dp_sh    <= DP_IN;
                            r_blank_sh <= BLANK_IN;
                            FRAME_DONE <= 1'b1;
                        end
                    end
                end
                S_GUARD: begin
                    // Ticks landing here are intentionally ignored.
                    if (r_gcnt == GUARD_LAST) begin
                        r_state <= S_ON;
                        r_idx   <= r_idx + 2'd1;
                    end else begin
                        r_gcnt <= r_gcnt + 16'd1;
                    end
                end
                default: r_state <= S_OFF;
            endcase

            // Drives follow the current state, so they all move one cycle after it.
            if ((r_state == S_ON) && !w_dark) begin
                AN  <= ~(4'b0001 << r_idx);
                SEG <= f_decode(w_nib);
                DP  <= ~r_dp_sh[r_idx];
            end else begin
                AN  <= 4'hF;
                SEG <= 7'h7F;
                DP  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_display_scan.sv
// Directed bench for seg_display_scan: reset, scan order, frame latching, LZS, guard gap, blank/DP.
`timescale 1ns/1ps
module tb_seg_display_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic        dclk;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic [3:0]  an0, an1;
    logic [6:0]  seg0, seg1;
    logic        dp0, dp1;
    logic        fd0, fd1;

    int checks = 0;
    int errors = 0;
    int fd_cnt = 0;

    always #5 clk = ~clk;

    seg_display_scan #(.GUARD_CYCLES(16), .LZS(1'b1)) u_lzs (
        .CLK100MHz(clk), .RST(rst), .DisplayCLK(dclk), .VALUE(value),
        .DP_IN(dp_in), .BLANK_IN(blank_in),
        .AN(an0), .SEG(seg0), .DP(dp0), .FRAME_DONE(fd0)
    );

    seg_display_scan #(.GUARD_CYCLES(16), .LZS(1'b0)) u_nolzs (
        .CLK100MHz(clk), .RST(rst), .DisplayCLK(dclk), .VALUE(value),
        .DP_IN(dp_in), .BLANK_IN(blank_in),
        .AN(an1), .SEG(seg1), .DP(dp1), .FRAME_DONE(fd1)
    );

    always @(negedge clk) if (fd0) fd_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One DisplayCLK pulse, then wait long enough for the next digit to be lit and stable.
    task automatic tick_settle();
        @(negedge clk) dclk = 1'b1;
        repeat (3) @(negedge clk);
        dclk = 1'b0;
        repeat (27) @(negedge clk);
    endtask

    task automatic chk_digit(input string tag, input logic [3:0] an_e,
                             input logic [6:0] seg_e, input logic dp_e);
        chk({tag, "_an"},  an0,  an_e);
        chk({tag, "_seg"}, seg0, seg_e);
        chk({tag, "_dp"},  dp0,  dp_e);
    endtask

    logic [3:0] an_tab  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] seg1234 [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
    logic [6:0] segabcd [4] = '{7'h21, 7'h46, 7'h03, 7'h08};

    initial begin
        int gcnt;
        bit relit;
        rst = 1'b1; dclk = 1'b0; value = 16'h1234; dp_in = 4'h0; blank_in = 4'h0;
        repeat (3) @(negedge clk);
        chk("rst_an", an0, 4'hF);
        chk("rst_seg", seg0, 7'h7F);
        chk("rst_dp", dp0, 1'b1);
        chk("rst_fd", fd0, 1'b0);
        rst = 1'b0;

        // T1: reset while digit 2 is lit
        repeat (3) tick_settle();
        chk_digit("t1_d2", 4'b1011, 7'h24, 1'b1);
        rst = 1'b1;
        #1;
        chk("t1_async_an", an0, 4'hF);
        chk("t1_async_seg", seg0, 7'h7F);
        chk("t1_async_dp", dp0, 1'b1);
        @(negedge clk) rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("t1_off_an", an0, 4'hF);

        // T2: plain scan of 1234 for two frames
        fd_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            tick_settle();
            chk_digit($sformatf("t2_k%0d", k), an_tab[k % 4], seg1234[k % 4], 1'b1);
        end
        chk("t2_frames", fd_cnt, 2);

        // T3: value change mid-frame must not tear
        tick_settle();
        chk_digit("t3_d0", an_tab[0], seg1234[0], 1'b1);
        tick_settle();
        value = 16'hABCD;
        chk_digit("t3_d1", an_tab[1], seg1234[1], 1'b1);
        for (int k = 2; k < 4; k++) begin
            tick_settle();
            chk_digit($sformatf("t3_old%0d", k), an_tab[k], seg1234[k], 1'b1);
        end
        for (int k = 0; k < 4; k++) begin
            tick_settle();
            chk_digit($sformatf("t3_new%0d", k), an_tab[k], segabcd[k], 1'b1);
        end

        // T4: leading-zero suppression
        value = 16'h0005;
        tick_settle();
        chk_digit("t4_d0", 4'b1110, 7'h12, 1'b1);
        chk("t4_nolzs_d0", seg1, 7'h12);
        for (int k = 1; k < 4; k++) begin
            tick_settle();
            chk_digit($sformatf("t4_dark%0d", k), 4'hF, 7'h7F, 1'b1);
            chk($sformatf("t4_nolzs_an%0d", k), an1, an_tab[k]);
            chk($sformatf("t4_nolzs_seg%0d", k), seg1, 7'h40);
        end
        value = 16'h0000;
        tick_settle();
        chk_digit("t4_zero", 4'b1110, 7'h40, 1'b1);

        // T5: guard gap width, measured on the always-lit instance
        gcnt = 0; relit = 1'b0;
        @(negedge clk) dclk = 1'b1;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (i == 2) dclk = 1'b0;
            if (an1 == 4'hF) gcnt++;
            else if (gcnt > 0) begin
                relit = 1'b1;
                break;
            end
        end
        chk("t5_relit", relit, 1'b1);
        chk("t5_guard_len", gcnt, 16);
        chk("t5_an_d1", an1, 4'b1101);
        repeat (20) @(negedge clk);

        // T5: a second pulse inside the guard must not advance the index
        @(negedge clk) dclk = 1'b1;
        relit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (an1 == 4'hF) begin
                relit = 1'b1;
                break;
            end
        end
        chk("t5_entered_guard", relit, 1'b1);
        dclk = 1'b0;
        repeat (2) @(negedge clk);
        dclk = 1'b1;
        repeat (2) @(negedge clk);
        dclk = 1'b0;
        repeat (40) @(negedge clk);
        chk("t5_one_adv", an1, 4'b1011);

        // T6: blanking and decimal points
        value = 16'h8888; blank_in = 4'b0100; dp_in = 4'b0010;
        tick_settle();
        chk_digit("t6_old_d3", 4'hF, 7'h7F, 1'b1);
        tick_settle();
        chk_digit("t6_d0", 4'b1110, 7'h00, 1'b1);
        tick_settle();
        chk_digit("t6_d1", 4'b1101, 7'h00, 1'b0);
        tick_settle();
        chk_digit("t6_d2", 4'hF, 7'h7F, 1'b1);
        tick_settle();
        chk_digit("t6_d3", 4'b0111, 7'h00, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
